// File: rtl/rv32m_muldiv_pkg.sv
// Shared definitions for the RV32M iterative multiply/divide unit:
// funct3 encodings, FSM state encoding, datapath width, iteration count
// and the fixed results returned for divide-by-zero and signed overflow.
package rv32m_muldiv_pkg;

    // Datapath width (XLEN); only 32 is supported.
    localparam int DEF_XLEN = 32;

    // funct3 encodings of the M extension.
    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // One result bit per cycle: 32 iterations, counter 0..31.
    localparam int         CNT_W    = 5;
    localparam logic [4:0] CNT_LAST = 5'd31;

    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] OVF_QUOT  = 32'h8000_0000;

    // rs1 is treated as signed for MULH, MULHSU, DIV and REM.
    function automatic logic rs1_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // rs2 is treated as signed for MULH, DIV and REM.
    function automatic logic rs2_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/rv32m_muldiv_negate.sv
// Conditional two's-complement negate (purely combinational).
// Ports:
//   neg  - when high, dout = -din; otherwise dout = din
//   din  - W-bit input value
//   dout - W-bit result
module rv32m_muldiv_negate #(
    parameter int W = 64
) (
    input  logic         neg,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    assign dout = neg ? (~din + {{(W-1){1'b0}}, 1'b1}) : din;

endmodule

// File: rtl/rv32m_muldiv.sv
// Iterative RV32M multiply/divide unit between register read and writeback.
// Operands are reduced to magnitudes on accept, processed one bit per cycle
// for 32 cycles (shift-add multiply or restoring divide sharing one 64-bit
// accumulator), sign-corrected in FIX and held in DONE until writeback takes
// them. Divide-by-zero and signed overflow answer in one cycle.
// Ports:
//   clk, reset              - clock, asynchronous active-high reset
//   io_req_valid/ready      - request handshake (ready only in IDLE)
//   io_req_funct3           - operation (MUL..REMU)
//   io_req_rs1_data/rs2_data- operands
//   io_req_rd_addr          - destination, returned with the result
//   io_kill                 - flush; drops in-flight or pending result
//   io_resp_valid/ready     - response handshake
//   io_resp_data/rd_addr    - result and its destination
//   io_busy                 - unit not idle
module rv32m_muldiv
    import rv32m_muldiv_pkg::*;
#(
    parameter int XLEN = DEF_XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            io_req_valid,
    output logic            io_req_ready,
    input  logic [2:0]      io_req_funct3,
    input  logic [XLEN-1:0] io_req_rs1_data,
    input  logic [XLEN-1:0] io_req_rs2_data,
    input  logic [4:0]      io_req_rd_addr,
    input  logic            io_kill,
    output logic            io_resp_valid,
    input  logic            io_resp_ready,
    output logic [XLEN-1:0] io_resp_data,
    output logic [4:0]      io_resp_rd_addr,
    output logic            io_busy
);

    state_t              state, state_next;
    logic [2:0]          f3_q;
    logic [4:0]          rd_q;
    logic                sign_a_q, sign_b_q;
    logic [CNT_W-1:0]    cnt;
    // Multiply: {partial product high, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits shifting into quotient}.
    logic [2*XLEN-1:0]   acc;
    // Multiplicand (multiply) or divisor magnitude (divide).
    logic [XLEN-1:0]     opnd;
    logic [XLEN-1:0]     resp_q;

    logic                accept;
    logic                req_is_div;
    logic                req_sign_a, req_sign_b;
    logic [XLEN-1:0]     mag_a, mag_b;
    logic                div_by_zero, div_ovf, special;
    logic [XLEN-1:0]     special_val;

    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next;
    logic [XLEN:0]       rem_sh;
    logic                rem_ge;
    logic [XLEN-1:0]     rem_sub;
    logic [2*XLEN-1:0]   div_next;

    logic                fix_neg;
    logic [2*XLEN-1:0]   fix_in, fix_out;
    logic [XLEN-1:0]     fix_data;

    assign io_req_ready    = (state == ST_IDLE);
    assign io_resp_valid   = (state == ST_DONE);
    assign io_busy         = (state != ST_IDLE);
    assign io_resp_data    = resp_q;
    assign io_resp_rd_addr = rd_q;

    // ---- Request decode / operand magnitudes ----
    assign accept     = io_req_valid & io_req_ready & ~io_kill;
    assign req_is_div = io_req_funct3[2];
    assign req_sign_a = rs1_signed(io_req_funct3) & io_req_rs1_data[XLEN-1];
    assign req_sign_b = rs2_signed(io_req_funct3) & io_req_rs2_data[XLEN-1];

    rv32m_muldiv_negate #(.W(XLEN)) u_mag_a (
        .neg  (req_sign_a),
        .din  (io_req_rs1_data),
        .dout (mag_a)
    );

    rv32m_muldiv_negate #(.W(XLEN)) u_mag_b (
        .neg  (req_sign_b),
        .din  (io_req_rs2_data),
        .dout (mag_b)
    );

    assign div_by_zero = req_is_div && (io_req_rs2_data == '0);
    assign div_ovf     = ((io_req_funct3 == F3_DIV) || (io_req_funct3 == F3_REM))
                         && (io_req_rs1_data == OVF_QUOT) && (io_req_rs2_data == '1);
    assign special     = div_by_zero | div_ovf;

    // funct3[1] separates remainder ops (REM/REMU) from quotient ops.
    always_comb begin
        special_val = '0;
        if (div_by_zero) begin
            special_val = io_req_funct3[1] ? io_req_rs1_data : DIV0_QUOT;
        end else if (div_ovf) begin
            special_val = io_req_funct3[1] ? '0 : OVF_QUOT;
        end
    end

    // ---- Iteration step ----
    // Shift-add: add multiplicand to the high half when the current
    // multiplier bit is set, then shift the whole accumulator right.
    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_next = {mul_sum, acc[XLEN-1:1]};

    // Restoring divide: bring in the next dividend bit; subtract the divisor
    // when it fits. The difference always fits in XLEN bits when taken.
    assign rem_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign rem_ge   = (rem_sh >= {1'b0, opnd});
    assign rem_sub  = rem_sh[XLEN-1:0] - opnd;
    assign div_next = rem_ge ? {rem_sub,            acc[XLEN-2:0], 1'b1}
                             : {rem_sh[XLEN-1:0],   acc[XLEN-2:0], 1'b0};

    // ---- Sign fix-up and result select ----
    always_comb begin
        fix_neg = 1'b0;
        fix_in  = acc;
        case (f3_q)
            F3_DIV, F3_DIVU: begin
                fix_in  = {{XLEN{1'b0}}, acc[XLEN-1:0]};
                fix_neg = sign_a_q ^ sign_b_q;
            end
            F3_REM, F3_REMU: begin
                fix_in  = {{XLEN{1'b0}}, acc[2*XLEN-1:XLEN]};
                fix_neg = sign_a_q;
            end
            default: begin
                fix_in  = acc;
                fix_neg = sign_a_q ^ sign_b_q;
            end
        endcase
    end

    rv32m_muldiv_negate #(.W(2*XLEN)) u_fix (
        .neg  (fix_neg),
        .din  (fix_in),
        .dout (fix_out)
    );

    always_comb begin
        fix_data = fix_out[XLEN-1:0];
        case (f3_q)
            F3_MULH, F3_MULHSU, F3_MULHU: fix_data = fix_out[2*XLEN-1:XLEN];
            default:                      fix_data = fix_out[XLEN-1:0];
        endcase
    end

    // ---- Control FSM ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept)             state_next = special ? ST_DONE : ST_CALC;
            ST_CALC: if (cnt == CNT_LAST)    state_next = ST_FIX;
            ST_FIX:                          state_next = ST_DONE;
            ST_DONE: if (io_resp_ready)      state_next = ST_IDLE;
            default:                         state_next = ST_IDLE;
        endcase
        // Flush overrides accept and the response handshake.
        if (io_kill) state_next = ST_IDLE;
    end

    // ---- Datapath registers ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f3_q     <= '0;
            rd_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            resp_q   <= '0;
        end else if (accept) begin
            f3_q     <= io_req_funct3;
            rd_q     <= io_req_rd_addr;
            sign_a_q <= req_sign_a;
            sign_b_q <= req_sign_b;
            cnt      <= '0;
            acc      <= {{XLEN{1'b0}}, (req_is_div ? mag_a : mag_b)};
            opnd     <= req_is_div ? mag_b : mag_a;
            if (special) resp_q <= special_val;
        end else if (state == ST_CALC) begin
            acc <= f3_q[2] ? div_next : mul_next;
            cnt <= cnt + 1'b1;
        end else if (state == ST_FIX) begin
            resp_q <= fix_data;
        end
    end

endmodule

// File: tb/tb_rv32m_muldiv.sv
module tb_rv32m_muldiv;
    import rv32m_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        io_req_valid;
    logic        io_req_ready;
    logic [2:0]  io_req_funct3;
    logic [31:0] io_req_rs1_data;
    logic [31:0] io_req_rs2_data;
    logic [4:0]  io_req_rd_addr;
    logic        io_kill;
    logic        io_resp_valid;
    logic        io_resp_ready;
    logic [31:0] io_resp_data;
    logic [4:0]  io_resp_rd_addr;
    logic        io_busy;

    always #5 clk = ~clk;

    rv32m_muldiv dut (
        .clk             (clk),
        .reset           (reset),
        .io_req_valid    (io_req_valid),
        .io_req_ready    (io_req_ready),
        .io_req_funct3   (io_req_funct3),
        .io_req_rs1_data (io_req_rs1_data),
        .io_req_rs2_data (io_req_rs2_data),
        .io_req_rd_addr  (io_req_rd_addr),
        .io_kill         (io_kill),
        .io_resp_valid   (io_resp_valid),
        .io_resp_ready   (io_resp_ready),
        .io_resp_data    (io_resp_data),
        .io_resp_rd_addr (io_resp_rd_addr),
        .io_busy         (io_busy)
    );

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        int          lat;
    } exp_t;

    vec_t vecs[12];
    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one request; the accept edge is the step() inside.
    task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit push, input logic [31:0] exp, input int lat);
        int w;
        w = 0;
        while (!io_req_ready && w < 100) begin
            step();
            w++;
        end
        if (!io_req_ready) begin
            total++;
            bad++;
            $display("FAIL req_ready_timeout: got 0, want 1");
        end
        io_req_valid    = 1'b1;
        io_req_funct3   = f3;
        io_req_rs1_data = a;
        io_req_rs2_data = b;
        io_req_rd_addr  = rd;
        step();
        io_req_valid = 1'b0;
        if (push) sb_q.push_back('{data: exp, rd: rd, lat: lat});
    endtask

    // Waits for the response, checks latency/data, optionally holds
    // backpressure for `hold` cycles, then completes the handshake.
    task automatic collect(input int hold);
        exp_t e;
        int   lat;
        lat = 1;
        while (!io_resp_valid && lat < 60) begin
            step();
            lat++;
        end
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty: got response, want none queued");
            return;
        end
        e = sb_q.pop_front();
        if (!io_resp_valid) begin
            total++;
            bad++;
            $display("FAIL resp_timeout: got no valid in %0d cycles, want latency %0d", lat, e.lat);
            return;
        end
        chk("latency", lat, e.lat);
        for (int i = 0; i < hold; i++) begin
            chk("bp_valid", io_resp_valid, 1);
            chk("bp_data", io_resp_data, e.data);
            chk("bp_rd", io_resp_rd_addr, e.rd);
            chk("bp_req_ready", io_req_ready, 0);
            step();
        end
        chk("data", io_resp_data, e.data);
        chk("rd", io_resp_rd_addr, e.rd);
        io_resp_ready = 1'b1;
        step();
        io_resp_ready = 1'b0;
        chk("hs_valid_low", io_resp_valid, 0);
        chk("hs_req_ready", io_req_ready, 1);
    endtask

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic        [63:0] ua, ub, p;
        logic               ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * $signed(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  rf3;
        logic [31:0] ra, rb;
        int          rlat;
        int          seen;

        vecs[0]  = '{F3_MUL,    32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 34};
        vecs[1]  = '{F3_MULH,   32'h8000_0000,  32'h8000_0000, 5'd1,  32'h4000_0000, 34};
        vecs[2]  = '{F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 34};
        vecs[3]  = '{F3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 34};
        vecs[4]  = '{F3_DIV,    32'hFFFF_FFF9,  32'd2,         5'd4,  32'hFFFF_FFFD, 34};
        vecs[5]  = '{F3_REM,    32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFF, 34};
        vecs[6]  = '{F3_DIVU,   32'd100,        32'd7,         5'd7,  32'd14,        34};
        vecs[7]  = '{F3_REMU,   32'd100,        32'd7,         5'd8,  32'd2,         34};
        vecs[8]  = '{F3_DIVU,   32'd5,          32'd0,         5'd9,  32'hFFFF_FFFF, 1};
        vecs[9]  = '{F3_REMU,   32'd5,          32'd0,         5'd10, 32'd5,         1};
        vecs[10] = '{F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1};
        vecs[11] = '{F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd0,  32'h0,         1};

        reset           = 1'b1;
        io_req_valid    = 1'b0;
        io_req_funct3   = '0;
        io_req_rs1_data = '0;
        io_req_rs2_data = '0;
        io_req_rd_addr  = '0;
        io_kill         = 1'b0;
        io_resp_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        step();

        chk("rst_req_ready", io_req_ready, 1);
        chk("rst_busy", io_busy, 0);
        chk("rst_resp_valid", io_resp_valid, 0);
        chk("rst_resp_data", io_resp_data, 0);
        chk("rst_resp_rd", io_resp_rd_addr, 0);

        for (int i = 0; i < 12; i++) begin
            send(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, 1'b1, vecs[i].exp, vecs[i].lat);
            collect(0);
        end

        for (int i = 0; i < 10; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            ra  = $urandom;
            case (i % 4)
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 50));
                default: rb = $urandom;
            endcase
            if (i == 5) begin
                rf3 = F3_REM;
                ra  = 32'h8000_0000;
                rb  = 32'hFFFF_FFFF;
            end
            rlat = (rf3[2] && ((rb == 0) || (((rf3 == F3_DIV) || (rf3 == F3_REM))
                   && (ra == 32'h8000_0000) && (rb == 32'hFFFF_FFFF)))) ? 1 : 34;
            send(rf3, ra, rb, 5'(i + 20), 1'b1, model(rf3, ra, rb), rlat);
            collect(0);
        end

        // Backpressure in DONE for 10 cycles.
        send(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17, 1'b1, 32'hFFFF_FFFE, 34);
        collect(10);

        // Kill on the 10th CALC edge: no response may ever appear.
        send(F3_MUL, 32'h0000_1234, 32'h0000_5678, 5'd3, 1'b0, 32'h0, 0);
        repeat (9) step();
        chk("calc_busy", io_busy, 1);
        io_kill = 1'b1;
        step();
        io_kill = 1'b0;
        chk("kill_req_ready", io_req_ready, 1);
        chk("kill_busy", io_busy, 0);
        chk("kill_valid", io_resp_valid, 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (io_resp_valid) seen = 1;
            step();
        end
        chk("kill_no_resp", seen, 0);

        // Kill together with a request in IDLE: the request is not taken.
        io_req_valid    = 1'b1;
        io_kill         = 1'b1;
        io_req_funct3   = F3_DIVU;
        io_req_rs1_data = 32'd5;
        io_req_rs2_data = 32'd0;
        io_req_rd_addr  = 5'd9;
        step();
        io_req_valid = 1'b0;
        io_kill      = 1'b0;
        chk("kill_idle_busy", io_busy, 0);
        chk("kill_idle_valid", io_resp_valid, 0);
        chk("kill_idle_ready", io_req_ready, 1);

        // Asynchronous reset in the middle of CALC.
        send(F3_DIVU, 32'd100, 32'd7, 5'd13, 1'b0, 32'h0, 0);
        repeat (5) step();
        #1;
        reset = 1'b1;
        #1;
        chk("areset_req_ready", io_req_ready, 1);
        chk("areset_busy", io_busy, 0);
        chk("areset_valid", io_resp_valid, 0);
        chk("areset_data", io_resp_data, 0);
        chk("areset_rd", io_resp_rd_addr, 0);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (io_resp_valid) seen = 1;
        end
        chk("areset_no_resp", seen, 0);

        // Normal operation resumes after reset.
        send(F3_REMU, 32'd100, 32'd7, 5'd31, 1'b1, 32'd2, 34);
        collect(0);

        chk("sb_drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
